mod3_pkt_arbiter: RTL and testbench
===================================

Name: mod3_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that shares one mod3_2 AXI-stream datapath among num_src upstream sources.
- Grants one source per packet and forwards its beats to the datapath input stream.
- Drives the datapath config_k with the granted source's k value, held stable for the whole packet.
- Sits directly in front of mod3_2; its m_* port and config_k connect to mod3_2 input_* and config_k.

Parameters:
- num_src, 4, number of requesting sources (2..8).
- data_width, 8, tdata width and config_k width.
- packet_length, 8, maximum beats per packet; the beat counter forces termination at this length.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- src_k  in  num_src*data_width  per-source k value; slice i belongs to source i.
- s_tdata  in  num_src*data_width  source data; slice i belongs to source i.
- s_tvalid  in  num_src  per-source valid.
- s_tlast  in  num_src  per-source last.
- s_tready  out  num_src  per-source ready; only the granted bit can be 1.
- m_tdata  out  data_width  data to the datapath.
- m_tvalid  out  1  valid to the datapath.
- m_tlast  out  1  last to the datapath.
- m_tready  in  1  ready from the datapath.
- config_k  out  data_width  k for the datapath; registered.
- grant_id  out  $clog2(num_src)  index of the granted source; registered.
- busy  out  1  high while in PASS.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, config_k=0, beat_cnt=0, busy=0. All s_tready, m_tvalid and m_tlast are 0 because they are gated by state.
- State IDLE:
  - If any s_tvalid is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - In the same edge, register grant_id=pick, config_k=src_k[pick], beat_cnt=0, rr_ptr=(pick+1) mod num_src.
  - Go to PASS.
  - If no valid is set, stay in IDLE and change nothing.
- State PASS (combinational passthrough):
  - m_tdata = s_tdata[grant_id].
  - m_tvalid = s_tvalid[grant_id].
  - s_tready[grant_id] = m_tready; all other s_tready bits are 0.
  - m_tlast = s_tlast[grant_id] OR (beat_cnt == packet_length-1).
- Beat accounting in PASS:
  - A beat is a cycle with m_tvalid & m_tready.
  - On a beat with m_tlast=0: beat_cnt increments.
  - On a beat with m_tlast=1: go to IDLE, beat_cnt=0.
- Latency: zero-cycle data path in PASS. There is exactly one idle bubble cycle (the IDLE arbitration cycle) before every packet.
- config_k and grant_id change only on the IDLE->PASS edge. Changes to src_k during a packet are ignored until the next grant.
- Early tlast (source ends before packet_length beats): the packet ends normally, with no error.
- Forced termination: at beat packet_length the block asserts m_tlast even if the source's s_tlast=0. Further beats from that source form a new packet on a later grant.
- Backpressure: m_tready=0 stalls the granted source. No beat is lost or duplicated, and beat_cnt does not advance.
- Granted source drops s_tvalid mid-packet: stay in PASS holding the grant, with no timeout.
- Simultaneous requests: round-robin from rr_ptr. A source that has just been served has the lowest priority in the next arbitration.
- reset_n low mid-packet: immediate return to reset values. The in-flight packet is truncated, and the downstream datapath is expected to be reset by the same reset_n.

Optional Feature:
- MOD3_ARB_LEN_ERR_EN defined:
  - Adds output len_err_cnt (16 bits, reset 0).
  - It increments on every forced-termination beat (the packet_length-th beat with s_tlast=0) and saturates at 16'hFFFF.
- Not defined: the port and counter are absent. Forced termination still happens.

Decomposition:
- Package mod3_pkg holds:
  - DATA_WIDTH=8 and PACKET_LENGTH=8 constants shared with mod3_2 and benches.
  - The state typedef enum {IDLE, PASS}.
- Sub-module mod3_rr_pick:
  - Combinational round-robin picker.
  - Inputs: req[num_src], ptr.
  - Outputs: valid, idx.
  - Instantiated once.

Test Plan:
- Single source 0, k=3, 8 beats data 1..8 with tlast on beat 8, m_tready=1 -> one IDLE bubble, then config_k=3 and grant_id=0; m_tdata 1..8 on consecutive cycles; m_tlast on beat 8; back to IDLE.
- Sources 0..3 all valid continuously, k=1,2,3,4 -> grant order 0,1,2,3,0; config_k 1,2,3,4,1 matches each packet; each packet is 8 beats.
- Source 2 sends 12 beats with tlast only on beat 12 -> first packet forced m_tlast on beat 8; next grant carries beats 9..12 with m_tlast on beat 12; len_err_cnt=1 when MOD3_ARB_LEN_ERR_EN is defined.
- Source 1 packet with m_tready toggling 1,0,0,1,... -> every data value appears exactly once in order; s_tready[1] mirrors m_tready; s_tready[0,2,3]=0 throughout.
- src_k[0] changes 3->5 at beat 4 of a source-0 packet -> config_k stays 3 to m_tlast; next source-0 packet shows 5.
- reset_n pulled low at beat 4 of a packet -> same-cycle m_tvalid=0, busy=0, config_k=0; after release, arbitration restarts from source 0.

Source files
------------

// File: rtl/mod3_pkg.sv
// rtl/mod3_pkg.sv - shared constants and state type for the mod3 datapath and its arbiter
//
// Holds the DATA_WIDTH / PACKET_LENGTH constants shared by mod3_2, the packet
// arbiter and the benches, plus the arbiter state encoding.
package mod3_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int PACKET_LENGTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mod3_rr_pick.sv
// rtl/mod3_rr_pick.sv - combinational round-robin picker
//
// Returns the first set request bit at or above ptr, wrapping past num_src-1
// back to 0.
//
// Ports:
//   req    in   num_src          request vector
//   ptr    in   $clog2(num_src)  search start index
//   valid  out  1                at least one request is set
//   idx    out  $clog2(num_src)  picked index (0 when valid=0)
module mod3_rr_pick
  import mod3_pkg::*;
#(
  parameter int num_src = 4
) (
  input  logic [num_src-1:0]         req,
  input  logic [$clog2(num_src)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(num_src)-1:0] idx
);

  localparam int idx_w = $clog2(num_src);

  int               cand;
  logic [idx_w-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < num_src; i++) begin
      // Candidate index walks ptr, ptr+1, ... modulo num_src.
      cand = int'(ptr) + i;
      if (cand >= num_src) begin
        cand = cand - num_src;
      end
      cand_idx = idx_w'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mod3_pkt_arbiter.sv
// rtl/mod3_pkt_arbiter.sv - packet-level round-robin arbiter in front of mod3_2
//
// Grants one source per packet, passes its beats through combinationally and
// holds config_k at the granted source's k for the whole packet. Packets are
// forcibly terminated after packet_length beats.
//
// Optional: define MOD3_ARB_LEN_ERR_EN to add len_err_cnt, a saturating count
// of forced-termination beats.
//
// Ports:
//   clk          in   1                    system clock
//   reset_n      in   1                    async active-low reset
//   src_k        in   num_src*data_width   per-source k (slice i = source i)
//   s_tdata      in   num_src*data_width   per-source data
//   s_tvalid     in   num_src              per-source valid
//   s_tlast      in   num_src              per-source last
//   s_tready     out  num_src              per-source ready (granted bit only)
//   m_tdata      out  data_width           data to datapath
//   m_tvalid     out  1                    valid to datapath
//   m_tlast      out  1                    last to datapath (source or forced)
//   m_tready     in   1                    ready from datapath
//   config_k     out  data_width           registered k for datapath
//   grant_id     out  $clog2(num_src)      registered granted source
//   busy         out  1                    high while passing a packet
//   len_err_cnt  out  16                   forced-termination count (optional)
module mod3_pkt_arbiter
  import mod3_pkg::*;
#(
  parameter int num_src       = 4,
  parameter int data_width    = DATA_WIDTH,
  parameter int packet_length = PACKET_LENGTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [num_src*data_width-1:0] src_k,
  input  logic [num_src*data_width-1:0] s_tdata,
  input  logic [num_src-1:0]            s_tvalid,
  input  logic [num_src-1:0]            s_tlast,
  output logic [num_src-1:0]            s_tready,
  output logic [data_width-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic [data_width-1:0]         config_k,
  output logic [$clog2(num_src)-1:0]    grant_id,
  output logic                          busy
`ifdef MOD3_ARB_LEN_ERR_EN
  ,
  output logic [15:0]                   len_err_cnt
`endif
);

  localparam int gid_w = $clog2(num_src);
  localparam int cnt_w = (packet_length > 1) ? $clog2(packet_length) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(packet_length - 1);
  localparam logic [gid_w-1:0] last_src  = gid_w'(num_src - 1);

  arb_state_t             state, state_nx;
  logic [gid_w-1:0]       rr_ptr, rr_ptr_nx;
  logic [gid_w-1:0]       grant_nx;
  logic [data_width-1:0]  k_nx;
  logic [cnt_w-1:0]       beat_cnt, cnt_nx;

  logic                   pick_valid;
  logic [gid_w-1:0]       pick_idx;

  logic [data_width-1:0]  data_a [num_src];
  logic [data_width-1:0]  k_a    [num_src];

  for (genvar i = 0; i < num_src; i++) begin : g_unpack
    assign data_a[i] = s_tdata[i*data_width +: data_width];
    assign k_a[i]    = src_k[i*data_width +: data_width];
  end

  mod3_rr_pick #(
    .num_src (num_src)
  ) u_pick (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy = (state == PASS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      config_k <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      grant_id <= grant_nx;
      config_k <= k_nx;
      beat_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    grant_nx  = grant_id;
    k_nx      = config_k;
    cnt_nx    = beat_cnt;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s_tready  = '0;

    case (state)
      IDLE: begin
        // Arbitration cycle: this is the single bubble ahead of each packet.
        if (pick_valid) begin
          state_nx  = PASS;
          grant_nx  = pick_idx;
          k_nx      = k_a[pick_idx];
          cnt_nx    = '0;
          // The winner drops to lowest priority for the next arbitration.
          rr_ptr_nx = (pick_idx == last_src) ? '0 : pick_idx + 1'b1;
        end
      end

      PASS: begin
        m_tdata            = data_a[grant_id];
        m_tvalid           = s_tvalid[grant_id];
        s_tready[grant_id] = m_tready;
        m_tlast            = s_tlast[grant_id] | (beat_cnt == last_beat);
        if (m_tvalid && m_tready) begin
          if (m_tlast) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx   = beat_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef MOD3_ARB_LEN_ERR_EN
  // A forced beat is the length-limit beat that the source did not mark last.
  logic forced_beat;

  assign forced_beat = busy & m_tvalid & m_tready &
                       (beat_cnt == last_beat) & ~s_tlast[grant_id];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_err_cnt <= '0;
    end else if (forced_beat && (len_err_cnt != 16'hFFFF)) begin
      len_err_cnt <= len_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mod3_pkt_arbiter.sv
// tb/tb_mod3_pkt_arbiter.sv - directed self-checking bench for mod3_pkt_arbiter
module tb_mod3_pkt_arbiter;
  import mod3_pkg::*;

  localparam int NS = 4;
  localparam int DW = DATA_WIDTH;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NS*DW-1:0] src_k;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;
  logic [DW-1:0]    config_k;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef MOD3_ARB_LEN_ERR_EN
  logic [15:0]      len_err_cnt;
`endif

  always #5 clk = ~clk;

  mod3_pkt_arbiter #(
    .num_src       (NS),
    .data_width    (DW),
    .packet_length (PACKET_LENGTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .src_k    (src_k),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .config_k (config_k),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef MOD3_ARB_LEN_ERR_EN
    ,
    .len_err_cnt (len_err_cnt)
`endif
  );

  typedef struct {
    int cyc;
    int data;
    int last;
    int gid;
    int k;
  } beat_t;

  beat_t log_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  // Source models: source i sends bytes base+idx, tlast every pkt beats.
  int src_idx [NS];
  int src_len [NS];
  int src_pkt [NS];
  int src_base[NS];
  int ka      [NS];
  int kb      [NS];
  int ksw     [NS];

  bit         mon_rdy  = 1'b0;
  bit         rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    vec_cnt++;
    if (got !== 32'(exp)) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic beat_t beat_at(input int i);
    beat_t b;
    b = '{cyc: -1, data: -1, last: -1, gid: -1, k: -1};
    if (i < log_q.size()) b = log_q[i];
    return b;
  endfunction

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      src_idx[i]  = 0;
      src_len[i]  = 0;
      src_pkt[i]  = 8;
      src_base[i] = 0;
      ka[i]       = 0;
      kb[i]       = 0;
      ksw[i]      = 1000;
    end
    mon_rdy  = 1'b0;
    rdy_mode = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      bit v;
      v = (src_idx[i] < src_len[i]);
      s_tvalid[i]       = v;
      s_tdata[i*DW +: DW] = v ? DW'(src_base[i] + src_idx[i]) : '0;
      s_tlast[i]        = v && ((src_idx[i] % src_pkt[i]) == src_pkt[i] - 1);
      src_k[i*DW +: DW] = DW'((src_idx[i] >= ksw[i]) ? kb[i] : ka[i]);
    end
    m_tready = rdy_mode ? rdy_pat[2'(cyc % 4)] : 1'b1;
  endtask

  task automatic step();
    logic [NS-1:0] fire;
    @(negedge clk);
    fire = s_tvalid & s_tready;
    if (mon_rdy && busy) check_eq("t4_s_tready", s_tready, {2'b00, m_tready, 1'b0});
    if (m_tvalid && m_tready)
      log_q.push_back('{cyc: cyc, data: int'(m_tdata), last: int'(m_tlast),
                        gid: int'(grant_id), k: int'(config_k)});
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) if (fire[i]) src_idx[i]++;
    drive();
  endtask

  task automatic run(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq({tag, "_beats_seen"}, 32'(log_q.size() >= n), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_srcs();
    cyc = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;

    // ---- reset values ----
    reset_n = 1'b0;
    clear_srcs();
    drive();
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_k", config_k, 0);
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_s_tready", s_tready, 0);

    // ---- test 1: single source 0, k=3, data 1..8 ----
    do_reset();
    src_len[0] = 8; src_base[0] = 1; ka[0] = 3;
    drive();
    run(8, 40, "t1");
    for (int j = 0; j < 8; j++) begin
      b = beat_at(j);
      check_eq($sformatf("t1_data%0d", j), b.data, j + 1);
      check_eq($sformatf("t1_cyc%0d", j), b.cyc, j + 1);
      check_eq($sformatf("t1_last%0d", j), b.last, (j == 7) ? 1 : 0);
    end
    b = beat_at(0);
    check_eq("t1_k", b.k, 3);
    check_eq("t1_gid", b.gid, 0);
    check_eq("t1_idle_after", busy, 0);

    // ---- test 2: four sources contending ----
    do_reset();
    for (int i = 0; i < NS; i++) begin
      src_len[i] = 16; src_base[i] = i * 32; ka[i] = i + 1;
    end
    drive();
    run(40, 100, "t2");
    begin
      int exp_gid[5] = '{0, 1, 2, 3, 0};
      int exp_k[5]   = '{1, 2, 3, 4, 1};
      int exp_d0[5]  = '{0, 32, 64, 96, 8};
      int nlast;
      nlast = 0;
      for (int p = 0; p < 5; p++) begin
        b = beat_at(8 * p);
        check_eq($sformatf("t2_gid_p%0d", p), b.gid, exp_gid[p]);
        check_eq($sformatf("t2_k_p%0d", p), b.k, exp_k[p]);
        check_eq($sformatf("t2_d0_p%0d", p), b.data, exp_d0[p]);
        b = beat_at(8 * p + 7);
        check_eq($sformatf("t2_last_p%0d", p), b.last, 1);
        if (p > 0) begin
          check_eq($sformatf("t2_bubble_p%0d", p),
                   beat_at(8 * p).cyc - beat_at(8 * p - 1).cyc, 2);
        end
      end
      for (int j = 0; j < 40; j++) nlast += (beat_at(j).last == 1) ? 1 : 0;
      check_eq("t2_last_count", nlast, 5);
    end

    // ---- test 3: source 2 sends 12 beats, tlast only on beat 12 ----
    do_reset();
    src_len[2] = 12; src_pkt[2] = 12; src_base[2] = 8'h40; ka[2] = 7;
    drive();
    run(12, 60, "t3");
    check_eq("t3_forced_last", beat_at(7).last, 1);
    check_eq("t3_beat8_data", beat_at(7).data, 8'h47);
    check_eq("t3_no_early_last", beat_at(6).last, 0);
    check_eq("t3_beat9_data", beat_at(8).data, 8'h48);
    check_eq("t3_beat9_gid", beat_at(8).gid, 2);
    check_eq("t3_regrant_bubble", beat_at(8).cyc - beat_at(7).cyc, 2);
    check_eq("t3_beat11_last", beat_at(10).last, 0);
    check_eq("t3_beat12_last", beat_at(11).last, 1);
`ifdef MOD3_ARB_LEN_ERR_EN
    check_eq("t3_len_err_cnt", len_err_cnt, 1);
`endif

    // ---- test 4: backpressure on source 1 ----
    do_reset();
    src_len[1] = 8; src_base[1] = 8'h10; ka[1] = 2;
    rdy_mode = 1'b1;
    mon_rdy  = 1'b1;
    drive();
    run(8, 60, "t4");
    repeat (4) step();
    mon_rdy = 1'b0;
    check_eq("t4_beat_count", log_q.size(), 8);
    for (int j = 0; j < 8; j++)
      check_eq($sformatf("t4_data%0d", j), beat_at(j).data, 8'h10 + j);
    check_eq("t4_stalled", 32'(beat_at(7).cyc - beat_at(0).cyc > 7), 1);

    // ---- test 5: src_k change mid-packet is ignored ----
    do_reset();
    src_len[0] = 16; ka[0] = 3; kb[0] = 5; ksw[0] = 3;
    drive();
    run(9, 60, "t5");
    check_eq("t5_k_beat4", beat_at(3).k, 3);
    check_eq("t5_k_beat8", beat_at(7).k, 3);
    check_eq("t5_last_beat8", beat_at(7).last, 1);
    check_eq("t5_k_next_pkt", beat_at(8).k, 5);
    check_eq("t5_gid_next_pkt", beat_at(8).gid, 0);

    // ---- test 6: reset in the middle of a packet ----
    do_reset();
    src_len[1] = 8; src_base[1] = 8'h70; ka[1] = 9;
    drive();
    run(4, 30, "t6");
    check_eq("t6_busy_pre", busy, 1);
    reset_n = 1'b0;
    #2;
    check_eq("t6_m_tvalid", m_tvalid, 0);
    check_eq("t6_m_tlast", m_tlast, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_k", config_k, 0);
    check_eq("t6_gid", grant_id, 0);
    check_eq("t6_s_tready", s_tready, 0);
    @(posedge clk);
    #1;
    clear_srcs();
    src_len[1] = 8; src_base[1] = 8'h70; ka[1] = 9;
    src_len[3] = 8; src_base[3] = 8'h30; ka[3] = 11;
    reset_n = 1'b1;
    cyc = 0;
    log_q.delete();
    drive();
    run(1, 20, "t6_post");
    check_eq("t6_post_gid", beat_at(0).gid, 1);
    check_eq("t6_post_k", beat_at(0).k, 9);
    check_eq("t6_post_data", beat_at(0).data, 8'h70);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
